// File: rtl/hydra_wrr_scheduler_if.sv
// hydra_wrr_scheduler_if: scheduler-to-queue-manager and read-engine signal bundle
interface hydra_wrr_scheduler_if #(
  parameter int NQ = 8,
  parameter int WW = 4
);
  logic                    wrr_en;
  logic [NQ*WW-1:0]        weight;
  logic [NQ-1:0]           q_nonempty;
  logic                    pause;
  logic                    rd_ready;
  logic                    pkt_done;
  logic                    grant_vld;
  logic [$clog2(NQ)-1:0]   grant_q;
  logic                    busy;
  logic                    err_timeout;
  modport master (
    output wrr_en, weight, q_nonempty, pause, rd_ready, pkt_done,
    input  grant_vld, grant_q, busy, err_timeout
  );
  modport slave (
    input  wrr_en, weight, q_nonempty, pause, rd_ready, pkt_done,
    output grant_vld, grant_q, busy, err_timeout
  );
endinterface

// File: rtl/hydra_wrr_scheduler.sv
// hydra_wrr_scheduler: per-port strict-priority / weighted-round-robin dequeue scheduler
module hydra_wrr_scheduler #(
  parameter int NQ      = 8,
  parameter int WW      = 4,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  hydra_wrr_scheduler_if.slave bus
);
  localparam int QW = $clog2(NQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t        state, state_nx;
  logic [WW-1:0] credit [NQ];
  logic [WW-1:0] cred_use [NQ];
  logic [WW-1:0] credit_nx [NQ];
  logic [WW-1:0] w;
  logic [NQ-1:0] elig;
  logic [QW-1:0] rr_ptr, rr_nx, sel, idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          grant, timeout, reload, found;
  // Selection: when no nonempty queue has credit left, the round restarts with
  // reloaded weights used directly in this cycle's scan.
  always_comb begin
    reload = 1'b1;
    sel    = '0;
    idx    = '0;
    found  = 1'b0;
    w      = '0;
    for (int q = 0; q < NQ; q++)
      if (bus.q_nonempty[q] && credit[q] != '0) reload = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      w           = bus.weight[q*WW +: WW];
      cred_use[q] = !reload ? credit[q] : (w == '0) ? WW'(1) : w;
      elig[q]     = bus.q_nonempty[q] && cred_use[q] != '0;
    end
    if (bus.wrr_en) begin
      for (int i = 0; i < NQ; i++) begin
        idx = QW'((int'(rr_ptr) + i) % NQ);
        if (!found && elig[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NQ - 1; i >= 0; i--)
        if (bus.q_nonempty[i]) sel = QW'(i);
    end
  end
  always_comb begin
    grant     = state == IDLE && !bus.pause && bus.rd_ready && |bus.q_nonempty;
    timeout   = state == SERVE && !bus.pkt_done && cnt == CW'(TIMEOUT - 1);
    state_nx  = grant ? SERVE : (state == SERVE && (bus.pkt_done || timeout)) ? IDLE : state;
    cnt_nx    = (state == SERVE && !bus.pkt_done && !timeout) ? cnt + 1'b1 : '0;
    credit_nx = credit;
    rr_nx     = rr_ptr;
    if (grant && bus.wrr_en) begin
      credit_nx      = cred_use;
      credit_nx[sel] = cred_use[sel] - WW'(cred_use[sel] != '0);
      rr_nx          = (credit_nx[sel] != '0) ? sel : (sel == QW'(NQ - 1)) ? '0 : sel + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state           <= IDLE;
      credit          <= '{default: '0};
      rr_ptr          <= '0;
      cnt             <= '0;
      bus.grant_vld   <= 1'b0;
      bus.grant_q     <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      credit          <= credit_nx;
      rr_ptr          <= rr_nx;
      cnt             <= cnt_nx;
      bus.grant_vld   <= grant;
      bus.err_timeout <= timeout;
      if (grant) bus.grant_q <= sel;
    end
  end
  assign bus.busy = state != IDLE;
endmodule

// File: doc/hydra_wrr_scheduler.md
Name: hydra_wrr_scheduler

Overview:
- Per-output-port dequeue scheduler for the hydra switch.
- Each output port holds NQ priority queues, indexed by the 3-bit priority field of the packet header.
- The block picks which queue the read engine drains next, using strict priority or weighted round robin (WRR) per the port's wrr_enable bit, and sequences one packet at a time via a grant/done handshake.
- One instance per output port (16 in hydra).

Parameters:
NQ, 8, number of priority queues (queue 0 = highest priority)
WW, 4, width of each queue weight / credit counter
TIMEOUT, 1024, max cycles in SERVE without pkt_done before forced abort

Ports:
clk  in  1  clock (all logic on rising edge)
rst_n  in  1  synchronous, active-high reset (kept codebase name; asserted = 1 resets)
wrr_en  in  1  1 = WRR mode, 0 = strict priority
weight  in  NQ*WW  per-queue weight; queue q at bits [q*WW +: WW]
q_nonempty  in  NQ  queue q holds at least one complete packet
pause  in  1  downstream back-pressure; blocks new grants only
rd_ready  in  1  read engine idle and able to accept a grant
pkt_done  in  1  one-cycle pulse: granted packet fully read out
grant_vld  out  1  one-cycle pulse: new grant issued
grant_q  out  3  queue granted; holds until next grant
busy  out  1  state != IDLE
err_timeout  out  1  one-cycle pulse on SERVE timeout

Behaviour:
- Reset (rst_n=1 at edge):
  - state=IDLE; grant_vld, grant_q, busy, err_timeout = 0.
  - All credits = 0; rr_ptr = 0; timeout counter = 0.
  - Applies from any state, including mid-SERVE.
- States: IDLE, SERVE.
- IDLE:
  - If !pause && rd_ready && q_nonempty != 0: select queue s combinationally, then at the edge load grant_q=s, pulse grant_vld for one cycle, update credits/pointer, go to SERVE.
  - Latency: grant_vld is high in the cycle after the edge at which the conditions were sampled.
- SERVE:
  - busy=1; counter increments each cycle.
  - pkt_done=1 -> IDLE and counter cleared.
  - Earliest next grant: the cycle after IDLE is re-entered (pkt_done at edge t -> IDLE -> grant_vld visible after edge t+1).
  - Counter reaches TIMEOUT-1 with no pkt_done -> pulse err_timeout, go to IDLE, credits untouched.
- pkt_done in IDLE is ignored. pause and rd_ready are ignored in SERVE.
- Strict mode (wrr_en=0): s = lowest-index set bit of q_nonempty. Credits and rr_ptr are frozen.
- WRR mode (wrr_en=1):
  - Effective weight w[q] = (weight[q]==0) ? 1 : weight[q].
  - eligible = q_nonempty & (credit != 0).
  - If eligible == 0: reload credit[q] = w[q] for all q in the same cycle and use the reloaded values for selection.
  - s = first eligible queue scanning circularly from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping mod NQ).
  - On grant: credit[s] -= 1. If the new credit is 0, rr_ptr = (s+1) mod NQ; otherwise rr_ptr = s, so the queue keeps service up to its weight.
- Credit arithmetic:
  - Unsigned, WW bits. Decrement only when credit != 0; never underflows.
  - Reload is a plain load from the weight port, not an add.
- Mode or weight changes take effect at the next arbitration. In-flight grants are unaffected.
- A queue emptying mid-round keeps its credit. The scan skips it because it fails the eligible mask.
- grant_q is stable between grants, so the datapath can sample it at any time during SERVE.

Test Plan:
1. Reset mid-SERVE (grant then rst_n=1 before pkt_done) -> next cycle busy=0, grant_vld=0, grant_q=0; after release a new grant restarts from rr_ptr=0.
2. Strict mode, q_nonempty=8'b1010_0100, rd_ready=1, pkt_done 3 cycles after each grant -> grant_q=2 every time while bit 2 stays set; after bit 2 clears -> grant_q=5.
3. WRR, weights q0=3, q1=1, q2=2, others 0, q_nonempty=8'h07 constant, immediate pkt_done -> grant sequence 0,0,0,1,2,2, then reload and repeat 0,0,0,1,2,2.
4. WRR, weight all 0, q_nonempty=8'h81 -> alternation 0,7,0,7 (weight 0 treated as 1); rr_ptr wraps 7->0.
5. pause=1 with q_nonempty=8'hFF -> no grant_vld for 20 cycles. pause drops -> grant_vld the next cycle. pause raised during SERVE -> pkt_done still returns the block to IDLE.
6. TIMEOUT=16, grant issued, pkt_done never sent -> err_timeout pulses 16 cycles after entering SERVE, busy falls, next grant follows on the next arbitration.
